instruction_fetch_unit: RTL and testbench

Pipelined-CPU fetch stage sitting directly upstream of the IF/ID pipeline registers. Owns the program counter, issues word-aligned requests to a variable-latency instruction memory (ROM or SPI flash), and presents one fetched instruction at a time with valid/stall handshaking. Accepts branch/jump redirects from later stages and discards in-flight responses that the redirect makes stale.

---
 rtl/instruction_fetch_unit.sv | 195 +++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage of a pipelined CPU, sitting just upstream of the IF/ID register.
// Owns the program counter, issues word-aligned requests to a variable-latency
// instruction memory, and presents one fetched instruction at a time.
// Branch/jump redirects from later stages restart fetching at a new address.
// A response still in flight when a redirect lands is squashed.
//
// Handshakes (valid/ready semantics, both directions):
//   * Memory side: o_mem_req is raised with o_mem_addr and both are held
//     unchanged until i_mem_ready is sampled high. i_mem_ready is a one-cycle
//     pulse qualifying i_mem_data, and it is ignored while o_mem_req is low.
//     A request is never withdrawn, even when a redirect makes it stale.
//   * Downstream side: o_if_valid marks o_if_pc/o_if_instruction as a
//     presented instruction. It is consumed on a cycle with o_if_valid=1 and
//     i_stall=0. While i_stall=1 every output holds.
//   * o_if_valid and o_mem_req are never high together.
//
// Every output is a register. The FSM state is exported on o_state for
// debug and checker binding.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_data,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instruction,
  output logic [31:0] o_fetch_count,
  output logic [1:0]  o_state
);

  // FETCH: a request is outstanding (or about to be issued after reset).
  // HOLD : an instruction is presented downstream, no request outstanding.
  // DRAIN: a request is outstanding, but its response is already stale.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pending_pc;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instruction;
  logic [31:0] r_fetch_count;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pending_pc_nxt;
  logic        w_mem_req_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic        w_if_valid_nxt;
  logic [31:0] w_if_pc_nxt;
  logic [31:0] w_if_instruction_nxt;
  logic [31:0] w_fetch_count_nxt;

  // Redirect target with the byte offset cleared so every fetch is aligned.
  logic [31:0] w_target;
  // Sequential successor of the presented instruction (wraps modulo 2^32).
  logic [31:0] w_pc_plus4;
  // Where fetching resumes once a squashed response has drained.
  logic [31:0] w_drain_dest;

  assign w_target     = i_redirect_pc & ~32'h0000_0003;
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_drain_dest = i_redirect ? w_target : r_pending_pc;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    w_state_nxt          = r_state;
    w_pc_nxt             = r_pc;
    w_pending_pc_nxt     = r_pending_pc;
    w_mem_req_nxt        = r_mem_req;
    w_mem_addr_nxt       = r_mem_addr;
    w_if_valid_nxt       = r_if_valid;
    w_if_pc_nxt          = r_if_pc;
    w_if_instruction_nxt = r_if_instruction;
    w_fetch_count_nxt    = r_fetch_count;

    unique case (r_state)
      S_FETCH: begin
        if (!r_mem_req) begin
          // First cycle out of reset: issue the request. A redirect seen
          // here simply changes where that first request goes.
          w_mem_req_nxt = 1'b1;
          if (i_redirect) begin
            w_pc_nxt       = w_target;
            w_mem_addr_nxt = w_target;
          end
        end else if (i_mem_ready) begin
          if (i_redirect) begin
            // Response belongs to the abandoned path: drop it and start
            // the new request immediately, keeping o_mem_req high.
            w_pc_nxt       = w_target;
            w_mem_addr_nxt = w_target;
          end else begin
            w_if_instruction_nxt = i_mem_data;
            w_if_pc_nxt          = r_pc;
            w_if_valid_nxt       = 1'b1;
            w_mem_req_nxt        = 1'b0;
            w_state_nxt          = S_HOLD;
          end
        end else if (i_redirect) begin
          // Request cannot be withdrawn; remember the target and wait.
          w_pending_pc_nxt = w_target;
          w_state_nxt      = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (i_mem_ready) begin
          // Stale data dropped; a redirect in this same cycle wins.
          w_pc_nxt       = w_drain_dest;
          w_mem_addr_nxt = w_drain_dest;
          w_state_nxt    = S_FETCH;
        end else if (i_redirect) begin
          // Last redirect wins.
          w_pending_pc_nxt = w_target;
        end
      end

      S_HOLD: begin
        if (i_redirect) begin
          // Redirect beats stall: the presented instruction is discarded.
          w_if_valid_nxt = 1'b0;
          w_pc_nxt       = w_target;
          w_mem_addr_nxt = w_target;
          w_mem_req_nxt  = 1'b1;
          w_state_nxt    = S_FETCH;
        end else if (!i_stall) begin
          // Accepted downstream: count it and fetch the next word.
          w_if_valid_nxt    = 1'b0;
          w_pc_nxt          = w_pc_plus4;
          w_mem_addr_nxt    = w_pc_plus4;
          w_mem_req_nxt     = 1'b1;
          w_fetch_count_nxt = r_fetch_count + 32'd1;
          w_state_nxt       = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state          <= S_FETCH;
      r_pc             <= RESET_PC;
      r_pending_pc     <= RESET_PC;
      r_mem_req        <= 1'b0;
      r_mem_addr       <= RESET_PC;
      r_if_valid       <= 1'b0;
      r_if_pc          <= 32'h0000_0000;
      r_if_instruction <= NOP;
      r_fetch_count    <= 32'h0000_0000;
    end else begin
      r_state          <= w_state_nxt;
      r_pc             <= w_pc_nxt;
      r_pending_pc     <= w_pending_pc_nxt;
      r_mem_req        <= w_mem_req_nxt;
      r_mem_addr       <= w_mem_addr_nxt;
      r_if_valid       <= w_if_valid_nxt;
      r_if_pc          <= w_if_pc_nxt;
      r_if_instruction <= w_if_instruction_nxt;
      r_fetch_count    <= w_fetch_count_nxt;
    end
  end

  assign o_mem_req        = r_mem_req;
  assign o_mem_addr       = r_mem_addr;
  assign o_if_valid       = r_if_valid;
  assign o_if_pc          = r_if_pc;
  assign o_if_instruction = r_if_instruction;
  assign o_fetch_count    = r_fetch_count;
  assign o_state          = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Drives the fetch unit with a behavioural instruction memory (programmable
// latency, data = (addr>>2) ^ salt), then a linear directed sequence followed
// by randomized stall/redirect/reset traffic. A transaction-level reference
// model predicts every output after each edge, and a scoreboard queue tracks
// the stream of presented instruction words.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset       = 1'b1;
  logic        i_stall       = 1'b0;
  logic        i_redirect    = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        i_mem_ready   = 1'b0;
  logic [31:0] i_mem_data    = 32'h0;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instruction;
  logic [31:0] o_fetch_count;
  logic [1:0]  o_state;

  instruction_fetch_unit dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .i_stall          (i_stall),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_mem_req        (o_mem_req),
    .o_mem_addr       (o_mem_addr),
    .i_mem_ready      (i_mem_ready),
    .i_mem_data       (i_mem_data),
    .o_if_valid       (o_if_valid),
    .o_if_pc          (o_if_pc),
    .o_if_instruction (o_if_instruction),
    .o_fetch_count    (o_fetch_count),
    .o_state          (o_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // Memory behaviour
  int          lat         = 1;
  int          mem_k       = 0;
  logic        force_ready = 1'b0;
  logic [31:0] salt        = 32'h0;

  // Reference model: expected outputs plus "squashed response pending" info
  logic        e_req   = 1'b0;
  logic [31:0] e_addr  = 32'h0;
  logic        e_valid = 1'b0;
  logic [31:0] e_pc    = 32'h0;
  logic [31:0] e_instr = NOP;
  logic [31:0] e_count = 32'h0;
  logic        m_squash = 1'b0;
  logic [31:0] m_next   = 32'h0;

  // Scoreboard of instruction words expected to be presented, in order
  logic [31:0] exp_q[$];
  logic        prev_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one clock edge, written from the fetch rules:
  // presenting / idle-after-reset / waiting on memory.
  task automatic model_edge(input logic st, input logic rd, input logic [31:0] rp,
                            input logic rst, input logic rdy);
    logic [31:0] tgt;
    tgt = rp & ~32'h3;
    if (rst) begin
      e_req = 1'b0; e_addr = 32'h0; e_valid = 1'b0; e_pc = 32'h0;
      e_instr = NOP; e_count = 32'h0; m_squash = 1'b0;
      exp_q.delete();
    end else if (e_valid) begin
      if (rd) begin
        e_valid = 1'b0; e_addr = tgt; e_req = 1'b1;
      end else if (!st) begin
        e_valid = 1'b0; e_addr = e_pc + 32'd4; e_req = 1'b1;
        e_count = e_count + 32'd1;
      end
    end else if (!e_req) begin
      e_req = 1'b1;
      if (rd) e_addr = tgt;
    end else if (rdy) begin
      if (rd) begin
        e_addr = tgt; m_squash = 1'b0;
      end else if (m_squash) begin
        e_addr = m_next; m_squash = 1'b0;
      end else begin
        e_valid = 1'b1; e_pc = e_addr; e_instr = mem_word(e_addr); e_req = 1'b0;
        exp_q.push_back(e_instr);
      end
    end else if (rd) begin
      m_squash = 1'b1; m_next = tgt;
    end
  endtask

  task automatic compare_all();
    chk("mem_req",        {31'b0, o_mem_req},  {31'b0, e_req});
    chk("mem_addr",       o_mem_addr,          e_addr);
    chk("if_valid",       {31'b0, o_if_valid}, {31'b0, e_valid});
    chk("if_pc",          o_if_pc,             e_pc);
    chk("if_instruction", o_if_instruction,    e_instr);
    chk("fetch_count",    o_fetch_count,       e_count);
    chk("valid_req_excl", {31'b0, o_if_valid & o_mem_req}, 32'h0);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic st, input logic rd, input logic [31:0] rp, input logic rst);
    logic rdy;
    @(negedge clk);
    if (rst) begin
      mem_k = 0; rdy = 1'b0;
    end else if (o_mem_req) begin
      mem_k++;
      rdy = force_ready || (mem_k >= lat);
    end else begin
      mem_k = 0; rdy = force_ready;
    end
    i_reset = rst; i_stall = st; i_redirect = rd; i_redirect_pc = rp;
    i_mem_ready = rdy; i_mem_data = mem_word(o_mem_addr);
    model_edge(st, rd, rp, rst, rdy);
    @(posedge clk);
    #1;
    if (rdy) mem_k = 0;
    compare_all();
    if (o_if_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL stream: observed=%h expected=<none>", o_if_instruction);
      end else begin
        chk("stream", o_if_instruction, exp_q.pop_front());
      end
    end
    prev_valid = o_if_valid;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic run_until_valid(input int max);
    for (int i = 0; i < max; i++) begin
      if (o_if_valid) break;
      step(1'b0, 1'b0, 32'h0, 1'b0);
    end
    chk("wait_valid", {31'b0, o_if_valid}, 32'h1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_mem_req",  {31'b0, o_mem_req}, 32'h0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_if_valid", {31'b0, o_if_valid}, 32'h0);
    chk("rst_if_instr", o_if_instruction, NOP);
    chk("rst_count",    o_fetch_count, 32'h0);

    // L=1 sequential stream: (0,0), (4,1), (8,2)
    idle(1);
    chk("first_req",  {31'b0, o_mem_req}, 32'h1);
    chk("first_addr", o_mem_addr, 32'h0);
    idle(1);
    chk("i0_pc", o_if_pc, 32'h0);
    chk("i0_in", o_if_instruction, 32'h0);
    idle(2);
    chk("i1_pc", o_if_pc, 32'h4);
    chk("i1_in", o_if_instruction, 32'h1);
    idle(2);
    chk("i2_pc", o_if_pc, 32'h8);
    chk("i2_in", o_if_instruction, 32'h2);

    // Stall for 5 cycles at if_pc=8
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      chk("stall_valid", {31'b0, o_if_valid}, 32'h1);
      chk("stall_pc",    o_if_pc, 32'h8);
      chk("stall_req",   {31'b0, o_mem_req}, 32'h0);
      chk("stall_count", o_fetch_count, 32'h2);
    end
    idle(1);
    chk("release_addr",  o_mem_addr, 32'hC);
    chk("release_count", o_fetch_count, 32'h3);

    // Redirect to 0x40 while 0x10 is outstanding (L=4)
    idle(1);
    lat = 4;
    idle(1);
    chk("req10_addr", o_mem_addr, 32'h10);
    step(1'b0, 1'b1, 32'h40, 1'b0);
    chk("drain_addr", o_mem_addr, 32'h10);
    idle(2);
    chk("drain_hold", o_mem_addr, 32'h10);
    idle(1);
    chk("after_drain_addr",  o_mem_addr, 32'h40);
    chk("after_drain_valid", {31'b0, o_if_valid}, 32'h0);
    run_until_valid(10);
    chk("redir40_pc", o_if_pc, 32'h40);
    chk("redir40_in", o_if_instruction, 32'h10);

    // Two redirects during DRAIN: last wins
    idle(1);
    step(1'b0, 1'b1, 32'h80, 1'b0);
    step(1'b0, 1'b1, 32'h90, 1'b0);
    idle(2);
    chk("last_wins_addr", o_mem_addr, 32'h90);
    run_until_valid(10);
    chk("redir90_pc", o_if_pc, 32'h90);

    // Redirect coinciding with mem_ready
    idle(1);
    idle(3);
    step(1'b0, 1'b1, 32'hA0, 1'b0);
    chk("coincide_addr",  o_mem_addr, 32'hA0);
    chk("coincide_valid", {31'b0, o_if_valid}, 32'h0);
    run_until_valid(10);
    chk("redirA0_pc", o_if_pc, 32'hA0);
    chk("redirA0_in", o_if_instruction, 32'h28);

    // Unaligned redirect in HOLD with stall=1
    step(1'b1, 1'b1, 32'h23, 1'b0);
    chk("hold_redir_valid", {31'b0, o_if_valid}, 32'h0);
    chk("hold_redir_addr",  o_mem_addr, 32'h20);
    chk("hold_redir_count", o_fetch_count, 32'h6);
    run_until_valid(10);
    chk("redir20_pc", o_if_pc, 32'h20);

    // Wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run_until_valid(10);
    chk("wrap_pc", o_if_pc, 32'hFFFF_FFFC);
    idle(1);
    chk("wrap_addr",  o_mem_addr, 32'h0);
    chk("wrap_count", o_fetch_count, 32'h7);

    // Reset mid-request (L=6), then a stale mem_ready
    lat = 6;
    idle(3);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mid_rst_req",   {31'b0, o_mem_req}, 32'h0);
    chk("mid_rst_addr",  o_mem_addr, 32'h0);
    chk("mid_rst_pc",    o_if_pc, 32'h0);
    chk("mid_rst_instr", o_if_instruction, NOP);
    chk("mid_rst_count", o_fetch_count, 32'h0);
    force_ready = 1'b1;
    idle(1);
    force_ready = 1'b0;
    chk("stale_valid", {31'b0, o_if_valid}, 32'h0);
    chk("stale_req",   {31'b0, o_mem_req}, 32'h1);
    chk("stale_instr", o_if_instruction, NOP);
    lat = 1;
    run_until_valid(10);
    chk("post_rst_pc", o_if_pc, 32'h0);

    // Randomized traffic against the reference model
    salt = $urandom;
    for (int i = 0; i < 600; i++) begin
      logic st, rd, rst;
      logic [31:0] rp;
      if ($urandom_range(0, 19) == 0) lat = $urandom_range(1, 5);
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 99) < 8);
      rst = ($urandom_range(0, 199) == 0);
      rp  = $urandom;
      step(st, rd, rp, rst);
    end

    chk("stream_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
